// File: rtl/d_phy_tx_lane_sequencer.sv
`default_nettype none
// =====================================================================
// Module   : d_phy_tx_lane_sequencer
// Brief    : D-PHY HS transmit sequencer driving Clock/Data Lane PPI
// Revision : 1.0
// =====================================================================
module d_phy_tx_lane_sequencer #(
    parameter int N_LANES_MAX      = 4,
    parameter int WORD_W           = 8,
    parameter int BURST_W          = 16,
    parameter int TCLK_POST_CYCLES = 4
) (
    input  logic                             hs_tx_word_clk,
    input  logic                             rst_n,
    input  logic [$clog2(N_LANES_MAX+1)-1:0] cfg_active_lanes,
    input  logic                             cfg_clk_continuous,
    input  logic [WORD_W-1:0]                cfg_pad_byte,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [BURST_W-1:0]               req_burst_size,
    input  logic [N_LANES_MAX*WORD_W-1:0]    in_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic                             clk_tx_request_hs,
    input  logic                             clk_tx_ready_hs,
    output logic [N_LANES_MAX-1:0]           data_tx_request_hs,
    input  logic [N_LANES_MAX-1:0]           data_tx_ready_hs,
    output logic [N_LANES_MAX*WORD_W-1:0]    tx_data_hs,
    input  logic [N_LANES_MAX:0]             stopstate,
    output logic                             busy,
    output logic                             done,
    output logic                             err_underrun
);
    localparam int LW = $clog2(N_LANES_MAX+1);
    localparam int CW = 8;
    localparam logic [LW-1:0] C_MAX_LANES = LW'(N_LANES_MAX);
    localparam logic [CW-1:0] C_POST_LAST = CW'(TCLK_POST_CYCLES-1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CLK_REQ  = 3'd1,
        ST_DATA     = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_CLK_POST = 3'd4
    } state_t;

    state_t                         state, state_nxt;
    logic [LW-1:0]                  act_lanes, act_lanes_nxt;
    logic [BURST_W-1:0]             rem, rem_nxt;
    logic [N_LANES_MAX*WORD_W-1:0]  data_q, data_nxt;
    logic [N_LANES_MAX-1:0]         fill_q, fill_nxt;
    logic [N_LANES_MAX-1:0]         lane_req_q, lane_req_nxt;
    logic                           clk_req_q, clk_req_nxt;
    logic [CW-1:0]                  post_cnt, post_cnt_nxt;
    logic                           done_q, done_nxt;
    logic                           und_q, und_nxt;

    logic [1:0]                     rst_sync;
    logic                           rst_int_n;
    logic [LW-1:0]                  cfg_lanes;
    logic [LW-1:0]                  take;
    logic [N_LANES_MAX-1:0]         act_mask, cfg_mask, load_mask;
    logic                           beat, quiet, stop_ok;

    // Assertion is immediate, release is re-timed to the word clock.
    always_ff @(posedge hs_tx_word_clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    assign take = (rem < BURST_W'(act_lanes)) ? LW'(rem) : act_lanes;

    always_comb begin
        cfg_lanes = cfg_active_lanes;
        if (cfg_active_lanes == '0)
            cfg_lanes = LW'(1);
        else if (cfg_active_lanes > C_MAX_LANES)
            cfg_lanes = C_MAX_LANES;
        act_mask  = '0;
        cfg_mask  = '0;
        load_mask = '0;
        for (int i = 0; i < N_LANES_MAX; i++) begin
            act_mask[i]  = (LW'(i) < act_lanes);
            cfg_mask[i]  = (LW'(i) < cfg_lanes);
            load_mask[i] = (LW'(i) < take);
        end
    end

    assign beat    = &(data_tx_ready_hs | ~act_mask);
    assign quiet   = ~|(data_tx_ready_hs & act_mask);
    // A running continuous clock lane is never in stop state, so bit 0 is waived.
    assign stop_ok = (&(stopstate[N_LANES_MAX:1] | ~cfg_mask)) & (stopstate[0] | clk_req_q);
    assign req_ready = (state == ST_IDLE) && stop_ok;

    always_comb begin
        state_nxt     = state;
        act_lanes_nxt = act_lanes;
        rem_nxt       = rem;
        data_nxt      = data_q;
        fill_nxt      = fill_q;
        lane_req_nxt  = lane_req_q;
        clk_req_nxt   = clk_req_q;
        post_cnt_nxt  = post_cnt;
        done_nxt      = 1'b0;
        und_nxt       = 1'b0;
        in_ready      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (clk_req_q && !cfg_clk_continuous)
                    clk_req_nxt = 1'b0;
                if (req_valid && req_ready) begin
                    act_lanes_nxt = cfg_lanes;
                    rem_nxt       = req_burst_size;
                    if (req_burst_size == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        clk_req_nxt = 1'b1;
                        state_nxt   = ST_CLK_REQ;
                    end
                end
            end
            ST_CLK_REQ: begin
                clk_req_nxt = 1'b1;
                if (clk_tx_ready_hs && in_valid) begin
                    in_ready     = 1'b1;
                    data_nxt     = in_data;
                    fill_nxt     = load_mask;
                    rem_nxt      = rem - BURST_W'(take);
                    lane_req_nxt = act_mask;
                    state_nxt    = ST_DATA;
                end
            end
            ST_DATA: begin
                if (beat) begin
                    if (rem != '0) begin
                        if (in_valid) begin
                            in_ready = 1'b1;
                            data_nxt = in_data;
                            fill_nxt = load_mask;
                            rem_nxt  = rem - BURST_W'(take);
                        end else begin
                            // Starved slot: send pad and keep the byte count.
                            fill_nxt = '0;
                            und_nxt  = 1'b1;
                        end
                    end else begin
                        lane_req_nxt = '0;
                        fill_nxt     = '0;
                        state_nxt    = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (quiet) begin
                    post_cnt_nxt = '0;
                    state_nxt    = ST_CLK_POST;
                end
            end
            ST_CLK_POST: begin
                if (post_cnt == C_POST_LAST) begin
                    done_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                    if (!cfg_clk_continuous)
                        clk_req_nxt = 1'b0;
                end else begin
                    post_cnt_nxt = post_cnt + CW'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge hs_tx_word_clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state      <= ST_IDLE;
            act_lanes  <= LW'(1);
            rem        <= '0;
            data_q     <= '0;
            fill_q     <= '0;
            lane_req_q <= '0;
            clk_req_q  <= 1'b0;
            post_cnt   <= '0;
            done_q     <= 1'b0;
            und_q      <= 1'b0;
        end else begin
            state      <= state_nxt;
            act_lanes  <= act_lanes_nxt;
            rem        <= rem_nxt;
            data_q     <= data_nxt;
            fill_q     <= fill_nxt;
            lane_req_q <= lane_req_nxt;
            clk_req_q  <= clk_req_nxt;
            post_cnt   <= post_cnt_nxt;
            done_q     <= done_nxt;
            und_q      <= und_nxt;
        end
    end

    for (genvar g = 0; g < N_LANES_MAX; g++) begin : g_lane
        assign tx_data_hs[g*WORD_W +: WORD_W] = fill_q[g] ? data_q[g*WORD_W +: WORD_W] : cfg_pad_byte;
    end

    assign clk_tx_request_hs  = clk_req_q;
    assign data_tx_request_hs = lane_req_q;
    assign busy               = (state != ST_IDLE);
    assign done               = done_q;
    assign err_underrun       = und_q;
endmodule
`default_nettype wire

// File: tb/tb_d_phy_tx_lane_sequencer.sv
`default_nettype none
// =====================================================================
// Module   : tb_d_phy_tx_lane_sequencer
// Brief    : Randomised self-checking bench with a byte-level lane model
// Revision : 1.0
// =====================================================================
module tb_d_phy_tx_lane_sequencer;
    localparam int N   = 4;
    localparam int W   = 8;
    localparam int BW  = 16;
    localparam int T   = 4;
    localparam int LW  = $clog2(N+1);
    localparam logic [W-1:0] PAD = 8'hB8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [LW-1:0]   cfg_active_lanes;
    logic            cfg_clk_continuous;
    logic [W-1:0]    cfg_pad_byte;
    logic            req_valid, req_ready;
    logic [BW-1:0]   req_burst_size;
    logic [N*W-1:0]  in_data;
    logic            in_valid, in_ready;
    logic            clk_tx_request_hs, clk_tx_ready_hs;
    logic [N-1:0]    data_tx_request_hs, data_tx_ready_hs;
    logic [N*W-1:0]  tx_data_hs;
    logic [N:0]      stopstate;
    logic            busy, done, err_underrun;

    logic            stall, stop_hold;
    logic [1:0]      clk_rdy_d = 2'b00;

    int checks = 0;
    int errors = 0;

    logic [N*W-1:0]  chunk_q[$];
    logic [N*W-1:0]  obs_q[$];
    logic [W-1:0]    bytes_q[$];
    int res_acc_c, res_done_n, res_done_c, res_drop_c, res_rise_c;
    int res_exp_und, res_und, res_beats, res_pad, res_nch;
    bit res_data_bad, res_inactive_bad, res_any_req, res_clk_low;

    always #5 clk = ~clk;

    // Simple PHY: clock lane ready two cycles after request, data lanes follow request.
    always @(posedge clk) clk_rdy_d <= {clk_rdy_d[0], clk_tx_request_hs};
    assign clk_tx_ready_hs  = clk_rdy_d[1] & clk_tx_request_hs;
    assign data_tx_ready_hs = data_tx_request_hs & {N{~stall}};
    assign stopstate = stop_hold ? '0 :
        {~(data_tx_request_hs | data_tx_ready_hs), ~(clk_tx_request_hs | clk_tx_ready_hs)};

    d_phy_tx_lane_sequencer #(
        .N_LANES_MAX(N), .WORD_W(W), .BURST_W(BW), .TCLK_POST_CYCLES(T)
    ) dut (
        .hs_tx_word_clk     (clk),
        .rst_n              (rst_n),
        .cfg_active_lanes   (cfg_active_lanes),
        .cfg_clk_continuous (cfg_clk_continuous),
        .cfg_pad_byte       (cfg_pad_byte),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_burst_size     (req_burst_size),
        .in_data            (in_data),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .clk_tx_request_hs  (clk_tx_request_hs),
        .clk_tx_ready_hs    (clk_tx_ready_hs),
        .data_tx_request_hs (data_tx_request_hs),
        .data_tx_ready_hs   (data_tx_ready_hs),
        .tx_data_hs         (tx_data_hs),
        .stopstate          (stopstate),
        .busy               (busy),
        .done               (done),
        .err_underrun       (err_underrun)
    );

    // Runs one burst and records what the lanes carried; tests judge the results.
    task automatic run_burst(input int a_cfg, input int size, input bit seq,
                             input int gap_pct, input int gap_at, input int gap_len,
                             input int stall_pct);
        int a, nch, hs, gap_left, didx;
        bit acc, fin, prev0, bt;
        logic [W-1:0]   b;
        logic [N*W-1:0] v, padv;
        logic [N-1:0]   amask;
        a = (a_cfg == 0) ? 1 : (a_cfg > N) ? N : a_cfg;
        amask = '0;
        for (int i = 0; i < a; i++) amask[i] = 1'b1;
        padv = {N{PAD}};
        chunk_q.delete(); obs_q.delete(); bytes_q.delete();
        for (int k = 0; k < size; k++) begin
            b = seq ? W'(k) : W'($urandom_range(0, 255));
            if (b == PAD) b = ~PAD;
            bytes_q.push_back(b);
        end
        nch = (size + a - 1) / a;
        for (int k = 0; k < nch; k++) begin
            v = padv;
            for (int i = 0; i < a; i++)
                if (k*a + i < size) v[i*W +: W] = bytes_q[k*a + i];
            chunk_q.push_back(v);
        end
        res_acc_c = -1; res_done_n = 0; res_done_c = -1; res_drop_c = -1; res_rise_c = -1;
        res_exp_und = 0; res_und = 0; res_pad = 0; res_nch = nch;
        res_data_bad = 0; res_inactive_bad = 0; res_any_req = 0; res_clk_low = 0;
        hs = 0; gap_left = gap_len; acc = 0; fin = 0; prev0 = 0;
        cfg_active_lanes = LW'(a_cfg);
        req_burst_size   = BW'(size);
        req_valid        = 1'b1;
        for (int c = 0; c < 600 && !fin; c++) begin
            @(negedge clk);
            if (req_valid && req_ready && !acc) begin acc = 1; res_acc_c = c; end
            bt = data_tx_request_hs[0] && (&(data_tx_ready_hs | ~amask));
            if (bt) begin
                obs_q.push_back(tx_data_hs);
                if (!in_valid && hs*a < size) res_exp_und++;
            end
            if (in_valid && in_ready) hs++;
            if (err_underrun) res_und++;
            if (done) begin res_done_n++; res_done_c = c; end
            if (prev0 && !data_tx_request_hs[0]) res_drop_c = c;
            if (!prev0 && data_tx_request_hs[0]) res_rise_c = c;
            if (data_tx_request_hs[0]) res_any_req = 1;
            if (!clk_tx_request_hs) res_clk_low = 1;
            prev0 = data_tx_request_hs[0];
            for (int i = a; i < N; i++)
                if (data_tx_request_hs[i] || tx_data_hs[i*W +: W] != PAD) res_inactive_bad = 1;
            if (res_done_n > 0 && c >= res_done_c + 1) fin = 1;
            @(posedge clk); #1;
            if (acc) req_valid = 1'b0;
            stall = (stall_pct > 0) && ($urandom_range(0, 99) < stall_pct);
            if (acc && hs < nch) begin
                in_data = chunk_q[hs];
                if (gap_left > 0 && hs == gap_at && data_tx_request_hs[0]) begin
                    in_valid = 1'b0;
                    gap_left--;
                end else begin
                    in_valid = ($urandom_range(0, 99) >= gap_pct);
                end
            end else begin
                in_valid = 1'b0;
            end
        end
        req_valid = 1'b0; in_valid = 1'b0; stall = 1'b0;
        didx = 0;
        foreach (obs_q[j]) begin
            if (obs_q[j][W-1:0] == PAD) begin
                res_pad++;
                if (obs_q[j] != padv) res_data_bad = 1;
            end else begin
                if (didx >= nch || obs_q[j] != chunk_q[didx]) res_data_bad = 1;
                didx++;
            end
        end
        if (didx != nch) res_data_bad = 1;
        res_beats = obs_q.size();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (clk_tx_request_hs !== 1'b0) begin errors++; $display("FAIL rst_clk_req: got %b want 0", clk_tx_request_hs); end
        checks++; if (data_tx_request_hs !== '0) begin errors++; $display("FAIL rst_data_req: got %h want 0", data_tx_request_hs); end
        checks++; if (tx_data_hs !== {N{PAD}}) begin errors++; $display("FAIL rst_tx_data: got %h want %h", tx_data_hs, {N{PAD}}); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
        checks++; if (err_underrun !== 1'b0) begin errors++; $display("FAIL rst_underrun: got %b want 0", err_underrun); end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_full_burst();
        run_burst(4, 16, 1'b1, 0, -1, 0, 0);
        checks++; if (res_done_n != 1) begin errors++; $display("FAIL full_done_count: got %0d want 1", res_done_n); end
        checks++; if (res_beats != 4) begin errors++; $display("FAIL full_beats: got %0d want 4", res_beats); end
        checks++; if (res_data_bad) begin errors++; $display("FAIL full_lane_data: got bad=1 want 0"); end
        v_last_lane3: begin
            logic [N*W-1:0] last;
            last = (obs_q.size() > 3) ? obs_q[3] : '0;
            checks++; if (last[31:24] != 8'h0F) begin errors++; $display("FAIL full_lane3_last: got %h want 0f", last[31:24]); end
        end
        checks++; if (res_done_c - res_drop_c != T+1) begin errors++; $display("FAIL full_done_delay: got %0d want %0d", res_done_c - res_drop_c, T+1); end
        checks++; if (res_und != 0) begin errors++; $display("FAIL full_underrun: got %0d want 0", res_und); end
    endtask

    task automatic test_partial_burst();
        logic [N*W-1:0] last;
        run_burst(4, 10, 1'b1, 0, -1, 0, 0);
        checks++; if (res_beats != 3) begin errors++; $display("FAIL partial_beats: got %0d want 3", res_beats); end
        checks++; if (res_data_bad) begin errors++; $display("FAIL partial_lane_data: got bad=1 want 0"); end
        last = (obs_q.size() > 2) ? obs_q[2] : '0;
        checks++; if (last !== {PAD, PAD, 8'h09, 8'h08}) begin errors++; $display("FAIL partial_last_vec: got %h want %h", last, {PAD, PAD, 8'h09, 8'h08}); end
        checks++; if (res_und != 0) begin errors++; $display("FAIL partial_underrun: got %0d want 0", res_und); end
    endtask

    task automatic test_lane_mask();
        run_burst(2, 6, 1'b0, 0, -1, 0, 0);
        checks++; if (res_inactive_bad) begin errors++; $display("FAIL mask_inactive_lanes: got active=1 want 0"); end
        checks++; if (res_beats != 3) begin errors++; $display("FAIL mask_beats: got %0d want 3", res_beats); end
        checks++; if (res_data_bad) begin errors++; $display("FAIL mask_lane_data: got bad=1 want 0"); end
    endtask

    task automatic test_underrun();
        run_burst(4, 8, 1'b0, 0, 1, 2, 0);
        checks++; if (res_und != 2) begin errors++; $display("FAIL underrun_pulses: got %0d want 2", res_und); end
        checks++; if (res_pad != 2) begin errors++; $display("FAIL underrun_pad_beats: got %0d want 2", res_pad); end
        checks++; if (res_beats != 4) begin errors++; $display("FAIL underrun_beats: got %0d want 4", res_beats); end
        checks++; if (res_data_bad) begin errors++; $display("FAIL underrun_data: got bad=1 want 0"); end
    endtask

    task automatic test_zero_burst();
        run_burst(3, 0, 1'b0, 0, -1, 0, 0);
        checks++; if (res_done_n != 1) begin errors++; $display("FAIL zero_done_count: got %0d want 1", res_done_n); end
        checks++; if (res_done_c - res_acc_c != 1) begin errors++; $display("FAIL zero_done_delay: got %0d want 1", res_done_c - res_acc_c); end
        checks++; if (res_any_req) begin errors++; $display("FAIL zero_lane_activity: got 1 want 0"); end
    endtask

    task automatic test_clamp();
        run_burst(0, 3, 1'b0, 0, -1, 0, 0);
        checks++; if (res_beats != 3 || res_data_bad || res_inactive_bad) begin errors++; $display("FAIL clamp_zero_lanes: got beats %0d want 3", res_beats); end
        run_burst(7, 8, 1'b0, 0, -1, 0, 0);
        checks++; if (res_beats != 2 || res_data_bad) begin errors++; $display("FAIL clamp_high_lanes: got beats %0d want 2", res_beats); end
    endtask

    task automatic test_back_to_back();
        cfg_clk_continuous = 1'b1;
        run_burst(4, 4, 1'b0, 0, -1, 0, 0);
        checks++; if (res_done_n != 1) begin errors++; $display("FAIL b2b_first_done: got %0d want 1", res_done_n); end
        run_burst(4, 4, 1'b0, 0, -1, 0, 0);
        checks++; if (res_clk_low) begin errors++; $display("FAIL b2b_clk_dropped: got 1 want 0"); end
        checks++; if (res_rise_c - res_acc_c != 2) begin errors++; $display("FAIL b2b_data_latency: got %0d want 2", res_rise_c - res_acc_c); end
        checks++; if (res_data_bad || res_done_n != 1) begin errors++; $display("FAIL b2b_second_burst: got done %0d want 1", res_done_n); end
        cfg_clk_continuous = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (clk_tx_request_hs !== 1'b0) begin errors++; $display("FAIL b2b_clk_release: got %b want 0", clk_tx_request_hs); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int a, sz;
        for (int n = 0; n < 12; n++) begin
            a  = $urandom_range(0, 7);
            sz = $urandom_range(1, 24);
            run_burst(a, sz, 1'b0, 25, -1, 0, 20);
            checks++; if (res_done_n != 1) begin errors++; $display("FAIL rnd%0d_done: got %0d want 1", n, res_done_n); end
            checks++; if (res_data_bad) begin errors++; $display("FAIL rnd%0d_data: got bad=1 want 0 (a=%0d size=%0d)", n, a, sz); end
            checks++; if (res_und != res_exp_und) begin errors++; $display("FAIL rnd%0d_underrun: got %0d want %0d", n, res_und, res_exp_und); end
            checks++; if (res_beats != res_nch + res_exp_und) begin errors++; $display("FAIL rnd%0d_beats: got %0d want %0d", n, res_beats, res_nch + res_exp_und); end
            checks++; if (res_inactive_bad) begin errors++; $display("FAIL rnd%0d_inactive: got 1 want 0", n); end
        end
    endtask

    task automatic test_reset_mid_burst();
        int dn;
        bit seen;
        cfg_active_lanes = LW'(4);
        req_burst_size   = BW'(40);
        in_data          = {N{8'h5A}};
        in_valid         = 1'b1;
        req_valid        = 1'b1;
        seen = 0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            if (data_tx_request_hs[0]) seen = 1;
            if (req_ready) begin @(posedge clk); #1 req_valid = 1'b0; end
        end
        checks++; if (!seen) begin errors++; $display("FAIL mid_reach_data: got 0 want 1"); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (clk_tx_request_hs !== 1'b0 || data_tx_request_hs !== '0) begin errors++; $display("FAIL mid_async_drop: got clk %b data %h want 0", clk_tx_request_hs, data_tx_request_hs); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
        req_valid = 1'b0; in_valid = 1'b0; stop_hold = 1'b1;
        dn = 0;
        repeat (3) begin @(negedge clk); if (done) dn++; end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (5) begin @(negedge clk); if (done) dn++; end
        checks++; if (dn != 0) begin errors++; $display("FAIL mid_no_done: got %0d want 0", dn); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL mid_ready_held: got %b want 0", req_ready); end
        @(posedge clk); #1 stop_hold = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_ready_return: got %b want 1", req_ready); end
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        cfg_active_lanes = LW'(4);
        cfg_clk_continuous = 1'b0;
        cfg_pad_byte = PAD;
        req_valid = 1'b0;
        req_burst_size = '0;
        in_data = '0;
        in_valid = 1'b0;
        stall = 1'b0;
        stop_hold = 1'b0;
        test_reset();
        test_full_burst();
        test_partial_burst();
        test_lane_mask();
        test_underrun();
        test_zero_burst();
        test_clamp();
        test_back_to_back();
        test_random();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
